// File: rtl/cpu_phase_gen_if.sv
// rtl/cpu_phase_gen_if.sv - control/strobe bundle for cpu_phase_gen (step signal present with PHASE_GEN_STEP_EN)
interface cpu_phase_gen_if #(
    parameter int CNT_W  = 4,
    parameter int ICNT_W = 16
);
    logic              run;
    logic              halt;
`ifdef PHASE_GEN_STEP_EN
    logic              step;
`endif
    logic [CNT_W-1:0]  count;
    logic              control_clk;
    logic              clk;
    logic              fetch;
    logic              alu_clk;
    logic              running;
    logic [ICNT_W-1:0] icount;

    modport master (
`ifdef PHASE_GEN_STEP_EN
        input  step,
`endif
        input  run, halt,
        output count, control_clk, clk, fetch, alu_clk, running, icount
    );

    modport slave (
`ifdef PHASE_GEN_STEP_EN
        output step,
`endif
        output run, halt,
        input  count, control_clk, clk, fetch, alu_clk, running, icount
    );
endinterface

// File: rtl/cpu_phase_gen.sv
// rtl/cpu_phase_gen.sv - CPU instruction-cycle phase generator; optional single-step via PHASE_GEN_STEP_EN
module cpu_phase_gen #(
    parameter int CNT_W    = 4,
    parameter int ALU_SLOT = 12,
    parameter int ICNT_W   = 16
) (
    input  logic            master_clk,
    input  logic            rst,
    cpu_phase_gen_if.master bus
);

`ifdef PHASE_GEN_STEP_EN
    typedef enum logic [1:0] {IDLE, RUN, STOP, STEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_SLOT);

    state_t            state, state_next;
    logic [CNT_W-1:0]  count_q, count_next;
    logic [ICNT_W-1:0] icount_q, icount_next;
    logic              pending, pending_next;
    logic              running_next;
    logic              control_clk_q, clk_q, fetch_q, alu_clk_q, running_q;
    logic              stop_req, go_req, at_wrap;
`ifdef PHASE_GEN_STEP_EN
    logic              step_req;
    assign step_req = bus.step & ~bus.halt;
`endif

    assign stop_req = bus.halt | ~bus.run;
    assign go_req   = bus.run & ~bus.halt;
    assign at_wrap  = (count_q == '1);

    // Next state, next count and stop bookkeeping; a started cycle always runs to its wrap
    always_comb begin
        state_next   = state;
        count_next   = count_q;
        icount_next  = icount_q;
        pending_next = pending;
        case (state)
            IDLE, STOP: begin
                count_next = '0;
                if (go_req) begin
                    state_next = RUN;
`ifdef PHASE_GEN_STEP_EN
                end else if (step_req) begin
                    state_next = STEP;
`endif
                end
            end
            RUN: begin
                count_next = count_q + CNT_W'(1);
                if (at_wrap) begin
                    icount_next = icount_q + ICNT_W'(1);
                    if (pending || stop_req) begin
                        state_next   = STOP;
                        pending_next = 1'b0;
                    end
                end else begin
                    pending_next = pending | stop_req;
                end
            end
`ifdef PHASE_GEN_STEP_EN
            STEP: begin
                count_next = count_q + CNT_W'(1);
                if (at_wrap) begin
                    icount_next  = icount_q + ICNT_W'(1);
                    state_next   = STOP;
                    pending_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next   = IDLE;
                count_next   = '0;
                pending_next = 1'b0;
            end
        endcase
`ifdef PHASE_GEN_STEP_EN
        running_next = (state_next == RUN) || (state_next == STEP);
`else
        running_next = (state_next == RUN);
`endif
    end

    // State, counters and strobes registered together so strobes always match count
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count_q       <= '0;
            icount_q      <= '0;
            pending       <= 1'b0;
            running_q     <= 1'b0;
            control_clk_q <= 1'b1;
            clk_q         <= 1'b0;
            fetch_q       <= 1'b1;
            alu_clk_q     <= (ALU_SLOT != 0);
        end else begin
            state         <= state_next;
            count_q       <= count_next;
            icount_q      <= icount_next;
            pending       <= pending_next;
            running_q     <= running_next;
            control_clk_q <= ~count_next[0];
            clk_q         <= count_next[1];
            fetch_q       <= ~count_next[CNT_W-1];
            alu_clk_q     <= (count_next != ALU_CNT);
        end
    end

    assign bus.count       = count_q;
    assign bus.icount      = icount_q;
    assign bus.running     = running_q;
    assign bus.control_clk = control_clk_q;
    assign bus.clk         = clk_q;
    assign bus.fetch       = fetch_q;
    assign bus.alu_clk     = alu_clk_q;

endmodule

// File: doc/cpu_phase_gen.md
CPU_PHASE_GEN -- requirements
Module: cpu_phase_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 4, phase-counter width; instruction cycle = 2**CNT_W master_clk cycles; legal CNT_W >= 2.
REQ-002 SHALL have parameter ALU_SLOT, default 12, count value at which alu_clk pulses low; legal 0 <= ALU_SLOT < 2**CNT_W.
REQ-003 SHALL have parameter ICNT_W, default 16, instruction-counter width.
REQ-004 master_clk  input  1  sole clock; all flops on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level; 1 = start or keep sequencing, 0 = stop request.
REQ-007 halt  input  1  level; CPU halt request, 1 = stop request.
REQ-008 step  input  1  single-step pulse; port exists only with PHASE_GEN_STEP_EN.
REQ-009 count  output  CNT_W  current phase count.
REQ-010 control_clk  output  1  equals ~count[0].
REQ-011 clk  output  1  equals count[1].
REQ-012 fetch  output  1  equals ~count[CNT_W-1].
REQ-013 alu_clk  output  1  0 only when count == ALU_SLOT, else 1.
REQ-014 running  output  1  1 in RUN or STEP state.
REQ-015 icount  output  ICNT_W  completed instruction cycles.

Function
REQ-016 All outputs SHALL be driven from flops, with no combinational path from any input; strobes SHALL be computed from next-count so they stay aligned with count every cycle.
REQ-017 States SHALL be IDLE, RUN, STOP and STEP; count increments by 1 per master_clk only in RUN or STEP, and is held at 0 otherwise.
REQ-018 IDLE -> RUN SHALL occur when run=1 and halt=0 at a rising edge; the first increment (count 0 -> 1) happens at the next edge.
REQ-019 In RUN, a stop request (halt=1 or run=0) sampled in any cycle SHALL set a sticky pending flag; the flag clears only on reset or on entering STOP.
REQ-020 At wrap (count all-ones -> 0), icount SHALL increment by 1, wrapping at 2**ICNT_W-1 -> 0.
REQ-021 At wrap, the state SHALL become STOP if the flag is set, or if the stop request is present in the wrap cycle itself; otherwise it stays RUN.
REQ-022 A partial instruction cycle SHALL never be abandoned except by reset.
REQ-023 STOP -> RUN SHALL occur when run=1 and halt=0; if halt=1, the block stays in STOP regardless of run.
REQ-024 When run=1 and halt=1 are sampled together in IDLE, the block SHALL stay in IDLE.
REQ-025 Counter width arithmetic SHALL be modulo 2**CNT_W and 2**ICNT_W; no saturation.

Reset
REQ-026 rst=0 SHALL asynchronously force: state IDLE, count 0, icount 0, pending flag 0, running 0, control_clk 1, clk 0, fetch 1, alu_clk 1 (alu_clk is 0 instead if ALU_SLOT==0).
REQ-027 Reset asserted mid-cycle SHALL take effect immediately; count SHALL NOT complete and icount SHALL NOT increment.
REQ-028 Reset release SHALL need no synchronizer inside the block; the first sequencing edge is the first rising edge with rst=1.

Configuration
REQ-029 With macro PHASE_GEN_STEP_EN defined, the step port SHALL exist.
REQ-030 With PHASE_GEN_STEP_EN, a step pulse in IDLE or STOP with halt=0 SHALL enter STEP and run exactly 2**CNT_W master_clk cycles.
REQ-031 With PHASE_GEN_STEP_EN, at the end of the STEP cycle icount SHALL increment and the state SHALL go to STOP.
REQ-032 With PHASE_GEN_STEP_EN, step SHALL be ignored in RUN and STEP; if run and step are sampled together, run has priority.
REQ-033 Without PHASE_GEN_STEP_EN, the step port, STEP state and all related logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-034 Defaults, release reset, run=1 -> count cycles 0..15; clk=1 at counts 2,3,6,7,10,11,14,15; fetch=1 at counts 0..7; alu_clk=0 only at count 12; icount=1 after the first wrap.
REQ-035 halt pulsed 1 cycle at count 5 -> count continues to 15, wraps to 0, state STOP, running=0, icount +1; run=1 with halt=0 afterwards resumes counting.
REQ-036 rst=0 at count 9 with icount 3 -> count 0 and icount 0 immediately, without waiting for a clock edge; state IDLE.
REQ-037 PHASE_GEN_STEP_EN, STOP, step pulse -> exactly 16 counting cycles, icount +1, back in STOP; a step pulse during RUN changes nothing.
REQ-038 CNT_W=3, ALU_SLOT=6, ICNT_W=2, run=1 -> period 8, fetch=~count[2], alu_clk=0 at count 6, icount sequence 1,2,3,0 over 4 instruction cycles.
